// File: rtl/backbone_sweep_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// backbone_sweep_ctrl_pkg
// Shared definitions for the backbone sweep controller and its engine link:
//   - sweep_state_e  : controller FSM states
//   - BB_DATA_W      : width of one backbone_initial response word, which is
//                      also the data width used by backbone_initial_fix
//   - calc_j_width() : index width for J variable nodes (one spare bit so
//                      the value J itself is representable)
//   - calc_a_width() : symbol width for an alphabet of size A
// ----------------------------------------------------------------------------
package backbone_sweep_ctrl_pkg;

    localparam int BB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

    function automatic int calc_j_width(input int j);
        return $clog2(j) + 1;
    endfunction

    function automatic int calc_a_width(input int a);
        return $clog2(a) + 1;
    endfunction

endpackage

// File: rtl/backbone_sweep_ctrl_if.sv
// ----------------------------------------------------------------------------
// backbone_sweep_ctrl_if
// Link between the sweep controller and the backbone_initial_fix engine.
//   Request side (controller -> engine):
//     alpha_u     J*A*8      frame alpha values, stable for the whole sweep
//     x_initial   J*A_WIDTH  frame symbols, stable for the whole sweep
//     ind_j       J_WIDTH    excluded index for the current request
//     din_tvalid  1          request valid (engine has no backpressure)
//   Response side (engine -> controller):
//     backbone_initial_tvalid  1          response valid, in request order
//     backbone_initial         BB_DATA_W  response word
// Modports: master = controller, slave = engine.
// ----------------------------------------------------------------------------
interface backbone_sweep_ctrl_if
    import backbone_sweep_ctrl_pkg::*;
#(
    parameter int J = 14,
    parameter int A = 2
);

    localparam int J_WIDTH = calc_j_width(J);
    localparam int A_WIDTH = calc_a_width(A);

    logic [J*A*8-1:0]       alpha_u;
    logic [J*A_WIDTH-1:0]   x_initial;
    logic [J_WIDTH-1:0]     ind_j;
    logic                   din_tvalid;
    logic                   backbone_initial_tvalid;
    logic [BB_DATA_W-1:0]   backbone_initial;

    modport master (
        output alpha_u,
        output x_initial,
        output ind_j,
        output din_tvalid,
        input  backbone_initial_tvalid,
        input  backbone_initial
    );

    modport slave (
        input  alpha_u,
        input  x_initial,
        input  ind_j,
        input  din_tvalid,
        output backbone_initial_tvalid,
        output backbone_initial
    );

endinterface

// File: rtl/backbone_sweep_ctrl_sweep_max_tracker.sv
// ----------------------------------------------------------------------------
// sweep_max_tracker
// Running unsigned maximum of a stream of response words, with the index of
// the winning word. A word replaces the current best only when strictly
// greater, so on ties the earliest (lowest) index is kept. Starting from
// best_val = 0 / best_idx = 0 means the first non-zero word always wins and
// an all-zero sweep reports index 0.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear of best_val/best_idx (new sweep)
//   upd, idx, val : candidate word and its index
//   best_idx, best_val : registered current maximum
// ----------------------------------------------------------------------------
module sweep_max_tracker
    import backbone_sweep_ctrl_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 upd,
    input  logic [IDX_W-1:0]     idx,
    input  logic [BB_DATA_W-1:0] val,
    output logic [IDX_W-1:0]     best_idx,
    output logic [BB_DATA_W-1:0] best_val
);

    logic [IDX_W-1:0]     best_idx_r;
    logic [BB_DATA_W-1:0] best_val_r;
    logic                 take_s;

    assign take_s = upd && (val > best_val_r);

    // Best-so-far register: clear wins over update, strict compare on update.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_idx_r <= IDX_W'(0);
            best_val_r <= BB_DATA_W'(0);
        end else if (clr) begin
            best_idx_r <= IDX_W'(0);
            best_val_r <= BB_DATA_W'(0);
        end else if (take_s) begin
            best_idx_r <= idx;
            best_val_r <= val;
        end else begin
            best_idx_r <= best_idx_r;
            best_val_r <= best_val_r;
        end
    end

    assign best_idx = best_idx_r;
    assign best_val = best_val_r;

endmodule

// File: rtl/backbone_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// backbone_sweep_ctrl
// Initiator/collector for the backbone-initial product engine. A start pulse
// in IDLE latches one frame and issues J back-to-back requests (ind_j =
// 0..J-1). The J in-order responses are forwarded one cycle later tagged
// with their index, and the maximum response plus its index are reported
// with a one-cycle done pulse at the end of the sweep.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle sweep request (ignored unless IDLE)
//   alpha_u_in      frame alpha values, sampled on accepted start
//   x_initial_in    frame symbols, sampled on accepted start
//   busy            sweep in progress (ISSUE or DRAIN)
//   eng             engine link (master): frame, ind_j, din_tvalid out;
//                   backbone_initial_tvalid / backbone_initial in
//   result_tvalid, result_idx, result_data   forwarded response stream
//   done            one-cycle pulse, sweep complete
//   best_idx, best_val   maximum response and its index, valid with done
//   err_unexpected  sticky: response arrived with nothing outstanding
//   err_timeout     sticky: no response for TIMEOUT cycles while draining
// ----------------------------------------------------------------------------
module backbone_sweep_ctrl
    import backbone_sweep_ctrl_pkg::*;
#(
    parameter  int J       = 14,
    parameter  int A       = 2,
    parameter  int TIMEOUT = 64,
    localparam int J_WIDTH = calc_j_width(J),
    localparam int A_WIDTH = calc_a_width(A)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [J*A*8-1:0]         alpha_u_in,
    input  logic [J*A_WIDTH-1:0]     x_initial_in,
    output logic                     busy,
    backbone_sweep_ctrl_if.master    eng,
    output logic                     result_tvalid,
    output logic [J_WIDTH-1:0]       result_idx,
    output logic [BB_DATA_W-1:0]     result_data,
    output logic                     done,
    output logic [J_WIDTH-1:0]       best_idx,
    output logic [BB_DATA_W-1:0]     best_val,
    output logic                     err_unexpected,
    output logic                     err_timeout
);

    // The counter must be able to hold TIMEOUT itself for one cycle.
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    sweep_state_e state_r;
    sweep_state_e state_nxt_s;

    logic [J*A*8-1:0]      alpha_u_r;
    logic [J*A_WIDTH-1:0]  x_initial_r;
    logic                  busy_r;
    logic                  din_tvalid_r;
    logic [J_WIDTH-1:0]    issue_cnt_r;
    logic [J_WIDTH-1:0]    resp_cnt_r;
    logic [J_WIDTH-1:0]    outstanding_r;
    logic [TMO_W-1:0]      tmo_cnt_r;
    logic                  result_tvalid_r;
    logic [J_WIDTH-1:0]    result_idx_r;
    logic [BB_DATA_W-1:0]  result_data_r;
    logic                  done_r;
    logic                  err_unexpected_r;
    logic                  err_timeout_r;

    logic                  busy_nxt_s;
    logic                  din_tvalid_nxt_s;
    logic [J_WIDTH-1:0]    issue_cnt_nxt_s;
    logic                  done_nxt_s;

    logic                  start_acc_s;
    logic                  collecting_s;
    logic                  resp_acc_s;
    logic                  resp_unexp_s;
    logic                  last_issue_s;
    logic                  last_resp_s;
    logic                  tmo_hit_s;

    assign start_acc_s  = (state_r == ST_IDLE) && start;
    assign collecting_s = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);

    // A response is only consumed while a sweep is collecting and something
    // is outstanding; everything else is dropped and flagged. Outstanding
    // counts requests issued in earlier cycles, so a request and a response
    // in the same cycle leave it unchanged.
    assign resp_acc_s   = eng.backbone_initial_tvalid && collecting_s &&
                          (outstanding_r != J_WIDTH'(0));
    assign resp_unexp_s = eng.backbone_initial_tvalid && !resp_acc_s;

    assign last_issue_s = (state_r == ST_ISSUE) && (issue_cnt_r == J_WIDTH'(J - 1));
    assign last_resp_s  = resp_acc_s && (resp_cnt_r == J_WIDTH'(J - 1));
    // This cycle is the TIMEOUT-th consecutive idle DRAIN cycle.
    assign tmo_hit_s    = (state_r == ST_DRAIN) && !resp_acc_s &&
                          (tmo_cnt_r == TMO_W'(TIMEOUT - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state plus next values of the state-derived registered outputs.
    always_comb begin
        state_nxt_s      = state_r;
        busy_nxt_s       = 1'b0;
        din_tvalid_nxt_s = 1'b0;
        issue_cnt_nxt_s  = J_WIDTH'(0);
        done_nxt_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (last_issue_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (last_resp_s || tmo_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the upcoming state.
        case (state_nxt_s)
            ST_ISSUE: begin
                busy_nxt_s       = 1'b1;
                din_tvalid_nxt_s = 1'b1;
                if (state_r == ST_ISSUE) begin
                    issue_cnt_nxt_s = issue_cnt_r + J_WIDTH'(1);
                end else begin
                    issue_cnt_nxt_s = J_WIDTH'(0);
                end
            end
            ST_DRAIN: begin
                busy_nxt_s = 1'b1;
            end
            ST_DONE: begin
                done_nxt_s = 1'b1;
            end
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Frame latch, request/response counters, result stream and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            alpha_u_r        <= (J*A*8)'(0);
            x_initial_r      <= (J*A_WIDTH)'(0);
            busy_r           <= 1'b0;
            din_tvalid_r     <= 1'b0;
            issue_cnt_r      <= J_WIDTH'(0);
            done_r           <= 1'b0;
            resp_cnt_r       <= J_WIDTH'(0);
            outstanding_r    <= J_WIDTH'(0);
            tmo_cnt_r        <= TMO_W'(0);
            result_tvalid_r  <= 1'b0;
            result_idx_r     <= J_WIDTH'(0);
            result_data_r    <= BB_DATA_W'(0);
            err_unexpected_r <= 1'b0;
            err_timeout_r    <= 1'b0;
        end else begin
            busy_r          <= busy_nxt_s;
            din_tvalid_r    <= din_tvalid_nxt_s;
            issue_cnt_r     <= issue_cnt_nxt_s;
            done_r          <= done_nxt_s;
            result_tvalid_r <= resp_acc_s;

            if (resp_acc_s) begin
                result_idx_r  <= resp_cnt_r;
                result_data_r <= eng.backbone_initial;
            end else begin
                result_idx_r  <= result_idx_r;
                result_data_r <= result_data_r;
            end

            if (start_acc_s) begin
                alpha_u_r        <= alpha_u_in;
                x_initial_r      <= x_initial_in;
                resp_cnt_r       <= J_WIDTH'(0);
                outstanding_r    <= J_WIDTH'(0);
                tmo_cnt_r        <= TMO_W'(0);
                // A stray response in the start cycle is still reported.
                err_unexpected_r <= resp_unexp_s;
                err_timeout_r    <= 1'b0;
            end else begin
                alpha_u_r     <= alpha_u_r;
                x_initial_r   <= x_initial_r;
                outstanding_r <= outstanding_r + J_WIDTH'(din_tvalid_r)
                                               - J_WIDTH'(resp_acc_s);
                if (resp_acc_s) begin
                    resp_cnt_r <= resp_cnt_r + J_WIDTH'(1);
                end else begin
                    resp_cnt_r <= resp_cnt_r;
                end
                if ((state_r == ST_DRAIN) && !resp_acc_s) begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                end else begin
                    tmo_cnt_r <= TMO_W'(0);
                end
                err_unexpected_r <= err_unexpected_r | resp_unexp_s;
                err_timeout_r    <= err_timeout_r | tmo_hit_s;
            end
        end
    end

    sweep_max_tracker #(
        .IDX_W (J_WIDTH)
    ) u_max_tracker (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc_s),
        .upd      (resp_acc_s),
        .idx      (resp_cnt_r),
        .val      (eng.backbone_initial),
        .best_idx (best_idx),
        .best_val (best_val)
    );

    assign eng.alpha_u    = alpha_u_r;
    assign eng.x_initial  = x_initial_r;
    assign eng.ind_j      = issue_cnt_r;
    assign eng.din_tvalid = din_tvalid_r;

    assign busy           = busy_r;
    assign done           = done_r;
    assign result_tvalid  = result_tvalid_r;
    assign result_idx     = result_idx_r;
    assign result_data    = result_data_r;
    assign err_unexpected = err_unexpected_r;
    assign err_timeout    = err_timeout_r;

endmodule

// File: tb/tb_backbone_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_backbone_sweep_ctrl
// Drives backbone_sweep_ctrl (J=4, A=2, TIMEOUT=8) against a latency-3 engine
// model. Expected results and sweep summaries are pushed to queues when a
// sweep is launched and popped by a monitor as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_backbone_sweep_ctrl;
    import backbone_sweep_ctrl_pkg::*;

    localparam int J       = 4;
    localparam int A       = 2;
    localparam int TIMEOUT = 8;
    localparam int J_WIDTH = calc_j_width(J);
    localparam int A_WIDTH = calc_a_width(A);
    localparam int LAT     = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [J*A*8-1:0]       alpha_u_in;
    logic [J*A_WIDTH-1:0]   x_initial_in;
    logic                   busy;
    logic                   result_tvalid;
    logic [J_WIDTH-1:0]     result_idx;
    logic [31:0]            result_data;
    logic                   done;
    logic [J_WIDTH-1:0]     best_idx;
    logic [31:0]            best_val;
    logic                   err_unexpected;
    logic                   err_timeout;

    backbone_sweep_ctrl_if #(.J(J), .A(A)) eng_if ();

    backbone_sweep_ctrl #(.J(J), .A(A), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .alpha_u_in     (alpha_u_in),
        .x_initial_in   (x_initial_in),
        .busy           (busy),
        .eng            (eng_if),
        .result_tvalid  (result_tvalid),
        .result_idx     (result_idx),
        .result_data    (result_data),
        .done           (done),
        .best_idx       (best_idx),
        .best_val       (best_val),
        .err_unexpected (err_unexpected),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard queues
    typedef struct packed {
        logic [J_WIDTH-1:0] idx;
        logic [31:0]        data;
    } res_t;
    typedef struct packed {
        logic [J_WIDTH-1:0] idx;
        logic [31:0]        val;
        logic               tmo;
    } sum_t;
    res_t exp_q[$];
    sum_t sum_q[$];
    int   done_cnt = 0;

    // Engine model controls
    logic [31:0] resp_tbl [J];
    bit          drop_last = 1'b0;
    bit          inj_v = 1'b0;
    logic [31:0] inj_d = 32'd0;

    // Engine model: fixed latency LAT, shares rst, optional drop of last response.
    initial begin
        logic        st_v [LAT];
        logic [31:0] st_d [LAT];
        for (int k = 0; k < LAT; k++) begin
            st_v[k] = 1'b0;
            st_d[k] = 32'd0;
        end
        eng_if.backbone_initial_tvalid = 1'b0;
        eng_if.backbone_initial        = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                for (int k = 0; k < LAT; k++) st_v[k] = 1'b0;
                eng_if.backbone_initial_tvalid = 1'b0;
            end else if (inj_v) begin
                eng_if.backbone_initial_tvalid = 1'b1;
                eng_if.backbone_initial        = inj_d;
            end else begin
                eng_if.backbone_initial_tvalid = st_v[LAT-1];
                eng_if.backbone_initial        = st_d[LAT-1];
                for (int k = LAT - 1; k > 0; k--) begin
                    st_v[k] = st_v[k-1];
                    st_d[k] = st_d[k-1];
                end
                st_v[0] = eng_if.din_tvalid &&
                          !(drop_last && (eng_if.ind_j == J_WIDTH'(J - 1)));
                st_d[0] = resp_tbl[eng_if.ind_j];
            end
        end
    end

    // Monitor: compare forwarded results and done summaries with the queues.
    initial begin
        res_t r;
        sum_t s;
        forever begin
            @(negedge clk);
            if (result_tvalid) begin
                if (exp_q.size() == 0) begin
                    check_val("result_unexpected", 64'd1, 64'd0);
                end else begin
                    r = exp_q.pop_front();
                    check_val("result_idx", result_idx, r.idx);
                    check_val("result_data", result_data, r.data);
                end
            end
            if (done) begin
                done_cnt++;
                if (sum_q.size() == 0) begin
                    check_val("done_unexpected", 64'd1, 64'd0);
                end else begin
                    s = sum_q.pop_front();
                    check_val("best_idx", best_idx, s.idx);
                    check_val("best_val", best_val, s.val);
                    check_val("err_timeout_at_done", err_timeout, s.tmo);
                    check_val("busy_at_done", busy, 1'b0);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_din_tvalid", eng_if.din_tvalid, 1'b0);
        check_val("rst_ind_j", eng_if.ind_j, 0);
        check_val("rst_result_tvalid", result_tvalid, 1'b0);
        check_val("rst_result_idx", result_idx, 0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_best_idx", best_idx, 0);
        check_val("rst_best_val", best_val, 0);
        check_val("rst_alpha_u", eng_if.alpha_u, 0);
        check_val("rst_x_initial", eng_if.x_initial, 0);
        check_val("rst_err_unexpected", err_unexpected, 1'b0);
        check_val("rst_err_timeout", err_timeout, 1'b0);
    endtask

    task automatic run_sweep(input logic [31:0] v0, input logic [31:0] v1,
                             input logic [31:0] v2, input logic [31:0] v3,
                             input bit drop, input bit mid_start, input bit do_reset,
                             input logic [J*A*8-1:0] alpha, input logic [J*A_WIDTH-1:0] xin);
        int               cnt;
        int               d0;
        bit               seen;
        logic [31:0]      bv;
        logic [J_WIDTH-1:0] bi;
        resp_tbl[0] = v0;
        resp_tbl[1] = v1;
        resp_tbl[2] = v2;
        resp_tbl[3] = v3;
        drop_last   = drop;
        // Reference model: in-order results, strict-greater running max.
        bv  = 32'd0;
        bi  = J_WIDTH'(0);
        cnt = 0;
        for (int i = 0; i < J; i++) begin
            if (!(drop && i == J - 1)) begin
                exp_q.push_back('{idx: J_WIDTH'(cnt), data: resp_tbl[i]});
                if (resp_tbl[i] > bv) begin
                    bv = resp_tbl[i];
                    bi = J_WIDTH'(cnt);
                end
                cnt++;
            end
        end
        if (!do_reset) sum_q.push_back('{idx: bi, val: bv, tmo: drop});

        @(negedge clk);
        start        = 1'b1;
        alpha_u_in   = alpha;
        x_initial_in = xin;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_rise", busy, 1'b1);
        check_val("err_unexpected_clr", err_unexpected, 1'b0);
        check_val("err_timeout_clr", err_timeout, 1'b0);
        check_val("best_val_clr", best_val, 0);
        check_val("alpha_latch", eng_if.alpha_u, alpha);
        check_val("x_latch", eng_if.x_initial, xin);
        for (int i = 0; i < J; i++) begin
            check_val("din_tvalid", eng_if.din_tvalid, 1'b1);
            check_val("ind_j", eng_if.ind_j, i);
            if (mid_start && i == 1) begin
                start        = 1'b1;
                alpha_u_in   = ~alpha;
                x_initial_in = ~xin;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check_val("din_tvalid_off", eng_if.din_tvalid, 1'b0);
        check_val("ind_j_off", eng_if.ind_j, 0);

        if (do_reset) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            exp_q.delete();
            sum_q.delete();
            check_reset_outputs();
        end else begin
            d0   = done_cnt;
            seen = 1'b0;
            for (int k = 0; k < 60 && !seen; k++) begin
                @(negedge clk);
                if (done_cnt != d0) seen = 1'b1;
            end
            check_val("done_seen", seen, 1'b1);
            repeat (12) @(negedge clk);
            check_val("done_once", done_cnt - d0, 1);
            check_val("busy_fall", busy, 1'b0);
            check_val("results_left", exp_q.size(), 0);
            check_val("alpha_hold", eng_if.alpha_u, alpha);
            check_val("x_hold", eng_if.x_initial, xin);
            check_val("best_idx_hold", best_idx, bi);
            check_val("best_val_hold", best_val, bv);
            check_val("err_timeout_sticky", err_timeout, drop);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        alpha_u_in   = '0;
        x_initial_in = '0;
        for (int i = 0; i < J; i++) resp_tbl[i] = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();

        // basic sweep, tie, start while busy, timeout with dropped last response
        run_sweep(32'd10, 32'd40, 32'd20, 32'd30, 1'b0, 1'b0, 1'b0, 64'h1122_3344_5566_7788, 8'hA5);
        run_sweep(32'd7,  32'd9,  32'd9,  32'd3,  1'b0, 1'b0, 1'b0, 64'h0102_0304_0506_0708, 8'h3C);
        run_sweep(32'd5,  32'd6,  32'd7,  32'd8,  1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 8'h5A);
        run_sweep(32'd50, 32'd60, 32'd55, 32'd99, 1'b1, 1'b0, 1'b0, 64'hCAFE_0000_1234_5678, 8'h0F);

        // unexpected response while idle
        @(negedge clk);
        inj_v = 1'b1;
        inj_d = 32'd5;
        @(negedge clk);
        inj_v = 1'b0;
        check_val("err_unexpected_set", err_unexpected, 1'b1);
        check_val("unexp_no_result", result_tvalid, 1'b0);
        @(negedge clk);
        check_val("err_unexpected_sticky", err_unexpected, 1'b1);

        // all-zero responses keep index 0; start clears the sticky errors
        run_sweep(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 64'h0F0F_F0F0_0F0F_F0F0, 8'h11);
        // reset mid-DRAIN, then a normal sweep
        run_sweep(32'd1, 32'd2, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 64'hAAAA_5555_AAAA_5555, 8'h22);
        run_sweep(32'd100, 32'd100, 32'd1, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, 64'h1357_9BDF_2468_ACE0, 8'h99);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
